mem_bus_arbiter: RTL and testbench

- Shares the single external memory port between the instruction-cache and data-cache miss controllers.
- Grants one requester at a time and holds the grant for the whole transaction. For reads, the transaction is the full line burst with re held high. For writes, it is the single word with wr held high.
- Routes address, data and ack between the granted requester and memory, and runs a watchdog on memory acks.

---
 rtl/mem_bus_arbiter_pkg.sv | 16 +
 rtl/mem_bus_arbiter_watchdog.sv | 46 ++++
 rtl/mem_bus_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding and
// requester identifiers used for round-robin bookkeeping.
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GNT_I   = 2'b01,
        ARB_GNT_D   = 2'b10,
        ARB_RELEASE = 2'b11
    } arb_state_t;

    // Requester identifiers; REQ_D doubles as the reset value of last_grant.
    localparam logic REQ_D = 1'b0;
    localparam logic REQ_I = 1'b1;

endpackage

// File: rtl/mem_bus_arbiter_watchdog.sv
// Watchdog on memory acks for the bus arbiter. Counts consecutive cycles in
// which the granted owner strobes memory without an ack. The cycle that would
// bring the count to TIMEOUT_CYCLES raises o_expire, which forces the arbiter
// into RELEASE; the sticky o_err flag is only cleared by ctr_rst.
module mem_bus_arbiter_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic clk,
    input  logic ctr_rst,
    input  logic i_active,
    input  logic i_ack,
    input  logic i_clear,
    output logic o_expire,
    output logic o_err
);

    localparam logic [TO_W-1:0] LAST_COUNT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_toCnt;
    logic            r_err;

    assign o_expire = i_active & ~i_ack & ~i_clear & (r_toCnt == LAST_COUNT);
    assign o_err    = r_err;

    // Count un-acked strobe cycles; any ack, leaving the grant states, or an expiry restarts the count.
    always_ff @(posedge clk or posedge ctr_rst) begin
        if (ctr_rst) begin
            r_toCnt <= '0;
        end else if (i_clear || i_ack || o_expire) begin
            r_toCnt <= '0;
        end else if (i_active) begin
            r_toCnt <= r_toCnt + 1'b1;
        end
    end

    // Latch the error flag on the first expiry and hold it until reset.
    always_ff @(posedge clk or posedge ctr_rst) begin
        if (ctr_rst) begin
            r_err <= 1'b0;
        end else if (o_expire) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one external memory port between the I-cache and D-cache
// miss controllers. The owner keeps the bus for as long as it holds its
// request; every hand-over passes through a RELEASE dead cycle and an IDLE
// cycle so memory always sees the strobes drop between owners.
// Optional build macro ARB_ROUND_ROBIN_EN: ties alternate between the sides
// instead of always favouring the D-side.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic                 clk,
    input  logic                 ctr_rst,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic                 i_re,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_ack,
    input  logic [ADDR_W-1:0]    d_addr,
    input  logic                 d_re,
    input  logic                 d_wr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_ack,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic                 mem_re,
    output logic                 mem_wr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack,
    output logic                 grant_i,
    output logic                 grant_d,
    output logic                 timeout_err
);

    arb_state_t r_state;
    logic       r_grantI;
    logic       r_grantD;

    logic w_reqI;
    logic w_reqD;
    logic w_tieWinner;
    logic w_inGrant;
    logic w_wdActive;
    logic w_expire;

    assign w_reqI = i_re;
    assign w_reqD = d_re | d_wr;

`ifdef ARB_ROUND_ROBIN_EN
    logic r_lastGrant;
    assign w_tieWinner = (r_lastGrant == REQ_I) ? REQ_D : REQ_I;
`else
    assign w_tieWinner = REQ_D;
`endif

    assign w_inGrant  = (r_state == ARB_GNT_I) || (r_state == ARB_GNT_D);
    assign w_wdActive = w_inGrant & (mem_re | mem_wr);

    assign grant_i = r_grantI;
    assign grant_d = r_grantD;

    mem_bus_arbiter_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_arb_watchdog (
        .clk      (clk),
        .ctr_rst  (ctr_rst),
        .i_active (w_wdActive),
        .i_ack    (mem_ack),
        .i_clear  (~w_inGrant),
        .o_expire (w_expire),
        .o_err    (timeout_err)
    );

    // Ownership FSM: pick a requester in IDLE, hold while it requests, then one dead cycle.
    always_ff @(posedge clk or posedge ctr_rst) begin
        if (ctr_rst) begin
            r_state  <= ARB_IDLE;
            r_grantI <= 1'b0;
            r_grantD <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_lastGrant <= REQ_D;
`endif
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_reqI && (!w_reqD || (w_tieWinner == REQ_I))) begin
                        r_state  <= ARB_GNT_I;
                        r_grantI <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_lastGrant <= REQ_I;
`endif
                    end else if (w_reqD) begin
                        r_state  <= ARB_GNT_D;
                        r_grantD <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        r_lastGrant <= REQ_D;
`endif
                    end
                end
                ARB_GNT_I: begin
                    if (!w_reqI || w_expire) begin
                        r_state  <= ARB_RELEASE;
                        r_grantI <= 1'b0;
                    end
                end
                ARB_GNT_D: begin
                    if (!w_reqD || w_expire) begin
                        r_state  <= ARB_RELEASE;
                        r_grantD <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ARB_IDLE;
                    r_grantI <= 1'b0;
                    r_grantD <= 1'b0;
                end
            endcase
        end
    end

    // Route address, strobes, data and ack between memory and the current owner only.
    always_comb begin
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_wr    = 1'b0;
        mem_wdata = '0;
        i_ack     = 1'b0;
        i_rdata   = '0;
        d_ack     = 1'b0;
        d_rdata   = '0;
        case (r_state)
            ARB_GNT_I: begin
                mem_addr = i_addr;
                mem_re   = i_re;
                i_ack    = mem_ack;
                i_rdata  = mem_rdata;
            end
            ARB_GNT_D: begin
                mem_addr  = d_addr;
                mem_re    = d_re;
                mem_wr    = d_wr;
                mem_wdata = d_wdata;
                d_ack     = mem_ack;
                d_rdata   = mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter. Directed scenarios exercise each
// behaviour, then a randomized run is compared cycle by cycle against an
// owner/dead-cycle reference model kept in the bench.
// Honours ARB_ROUND_ROBIN_EN the same way as the design.
module tb_mem_bus_arbiter;

    localparam int ADDR_W         = 32;
    localparam int WORD_SIZE      = 32;
    localparam int TIMEOUT_CYCLES = 4;
    localparam int TO_W           = 8;

    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic                 clk;
    logic                 ctr_rst;
    logic [ADDR_W-1:0]    i_addr;
    logic                 i_re;
    logic [WORD_SIZE-1:0] i_rdata;
    logic                 i_ack;
    logic [ADDR_W-1:0]    d_addr;
    logic                 d_re;
    logic                 d_wr;
    logic [WORD_SIZE-1:0] d_wdata;
    logic [WORD_SIZE-1:0] d_rdata;
    logic                 d_ack;
    logic [ADDR_W-1:0]    mem_addr;
    logic                 mem_re;
    logic                 mem_wr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [WORD_SIZE-1:0] mem_rdata;
    logic                 mem_ack;
    logic                 grant_i;
    logic                 grant_d;
    logic                 timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: who owns the bus, whether a dead cycle is pending,
    // how long the owner has waited for an ack, sticky error, last winner.
    int mOwner;
    bit mDead;
    int mWait;
    bit mErr;
    bit mLastI;

    mem_bus_arbiter #(
        .ADDR_W         (ADDR_W),
        .WORD_SIZE      (WORD_SIZE),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) dut (
        .clk         (clk),
        .ctr_rst     (ctr_rst),
        .i_addr      (i_addr),
        .i_re        (i_re),
        .i_rdata     (i_rdata),
        .i_ack       (i_ack),
        .d_addr      (d_addr),
        .d_re        (d_re),
        .d_wr        (d_wr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ack       (d_ack),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_wr      (mem_wr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .grant_i     (grant_i),
        .grant_d     (grant_d),
        .timeout_err (timeout_err)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "[TB] global time limit expired");
    end

    task automatic modelReset();
        mOwner = OWN_NONE;
        mDead  = 1'b0;
        mWait  = 0;
        mErr   = 1'b0;
        mLastI = 1'b0;
    endtask

    // One clock of the arbitration rules, applied to the inputs seen at the edge.
    task automatic modelStep();
        bit ri;
        bit rd;
        bit stillReq;
        ri = i_re;
        rd = d_re | d_wr;
        if (mOwner != OWN_NONE) begin
            stillReq = (mOwner == OWN_I) ? ri : rd;
            if (!stillReq) begin
                mOwner = OWN_NONE; mDead = 1'b1; mWait = 0;
            end else if (mem_ack) begin
                mWait = 0;
            end else begin
                mWait = mWait + 1;
                if (mWait >= TIMEOUT_CYCLES) begin
                    mOwner = OWN_NONE; mDead = 1'b1; mWait = 0; mErr = 1'b1;
                end
            end
        end else if (mDead) begin
            mDead = 1'b0;
        end else if (ri || rd) begin
            if (ri && rd) begin
`ifdef ARB_ROUND_ROBIN_EN
                mOwner = mLastI ? OWN_D : OWN_I;
`else
                mOwner = OWN_D;
`endif
            end else begin
                mOwner = ri ? OWN_I : OWN_D;
            end
            mLastI = (mOwner == OWN_I);
        end
    endtask

    // Advance one clock: model follows the active edge, return at the falling edge.
    task automatic cycle();
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        ctr_rst = 1'b1;
        i_re = 1'b1; d_wr = 1'b1; mem_ack = 1'b1; i_addr = 32'h1234; d_addr = 32'h5678;
        #1;
        vectors++; if (grant_i !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_grant_i: got %b want 0", grant_i); end
        vectors++; if (grant_d !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_grant_d: got %b want 0", grant_d); end
        vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_re: got %b want 0", mem_re); end
        vectors++; if (mem_wr !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mem_wr: got %b want 0", mem_wr); end
        vectors++; if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_mem_addr: got %h want 0", mem_addr); end
        vectors++; if (i_ack !== 1'b0 || d_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_acks: got i=%b d=%b want 0 0", i_ack, d_ack); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_timeout_err: got %b want 0", timeout_err); end
        i_re = 1'b0; d_wr = 1'b0; mem_ack = 1'b0; i_addr = '0; d_addr = '0;
        #1;
        ctr_rst = 1'b0;
        modelReset();
    endtask

    task automatic test_d_write();
        d_wr = 1'b1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF;
        #1;
        vectors++; if (grant_d !== 1'b0) begin miscompares++; $display("[TB] FAIL dwr_pre_grant: got %b want 0", grant_d); end
        cycle(); #1;
        vectors++; if (grant_d !== 1'b1 || grant_i !== 1'b0) begin miscompares++; $display("[TB] FAIL dwr_grant: got d=%b i=%b want 1 0", grant_d, grant_i); end
        vectors++; if (mem_wr !== 1'b1 || mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL dwr_strobes: got wr=%b re=%b want 1 0", mem_wr, mem_re); end
        vectors++; if (mem_addr !== 32'h2004) begin miscompares++; $display("[TB] FAIL dwr_addr: got %h want 00002004", mem_addr); end
        vectors++; if (mem_wdata !== 32'hDEADBEEF) begin miscompares++; $display("[TB] FAIL dwr_wdata: got %h want deadbeef", mem_wdata); end
        vectors++; if (d_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL dwr_ack_low: got %b want 0", d_ack); end
        mem_ack = 1'b1;
        #1;
        vectors++; if (d_ack !== 1'b1 || i_ack !== 1'b0) begin miscompares++; $display("[TB] FAIL dwr_ack_high: got d=%b i=%b want 1 0", d_ack, i_ack); end
        cycle();
        d_wr = 1'b0; mem_ack = 1'b0;
        cycle(); #1;
        vectors++; if (grant_d !== 1'b0 || mem_wr !== 1'b0) begin miscompares++; $display("[TB] FAIL dwr_release: got grant=%b wr=%b want 0 0", grant_d, mem_wr); end
        cycle();
    endtask

    task automatic test_i_burst();
        int ackCount;
        int beats;
        int gap;
        logic [WORD_SIZE-1:0] data;
        ackCount = 0; beats = 0; gap = 0;
        i_re = 1'b1; i_addr = 32'h1000;
        #1;
        vectors++; if (grant_i !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_pre_grant: got %b want 0", grant_i); end
        cycle(); #1;
        vectors++; if (grant_i !== 1'b1 || mem_re !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_grant: got grant=%b re=%b want 1 1", grant_i, mem_re); end
        vectors++; if (mem_addr !== 32'h1000) begin miscompares++; $display("[TB] FAIL burst_addr: got %h want 00001000", mem_addr); end
        for (int n = 0; n < 64 && beats < 16; n++) begin
            mem_ack = (gap >= 2) ? 1'b1 : ($urandom_range(0, 3) != 0);
            data = $urandom;
            mem_rdata = data;
            #1;
            if (i_ack === 1'b1) ackCount++;
            if (mem_ack) begin
                beats++; gap = 0;
                vectors++; if (i_rdata !== data) begin miscompares++; $display("[TB] FAIL burst_rdata: got %h want %h", i_rdata, data); end
            end else begin
                gap++;
            end
            vectors++; if (d_ack !== 1'b0 || d_rdata !== '0) begin miscompares++; $display("[TB] FAIL burst_d_side: got ack=%b rdata=%h want 0 0", d_ack, d_rdata); end
            vectors++; if (grant_i !== 1'b1) begin miscompares++; $display("[TB] FAIL burst_hold: got %b want 1", grant_i); end
            cycle();
        end
        vectors++; if (ackCount !== 16) begin miscompares++; $display("[TB] FAIL burst_ack_count: got %0d want 16", ackCount); end
        i_re = 1'b0; mem_ack = 1'b0;
        cycle(); #1;
        vectors++; if (grant_i !== 1'b0 || mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_release: got grant=%b re=%b want 0 0", grant_i, mem_re); end
        cycle(); #1;
        vectors++; if (grant_i !== 1'b0 || grant_d !== 1'b0) begin miscompares++; $display("[TB] FAIL burst_idle: got i=%b d=%b want 0 0", grant_i, grant_d); end
    endtask

    task automatic test_tie();
        bit expD;
        for (int k = 0; k < 3; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            expD = mLastI;
`else
            expD = 1'b1;
`endif
            $display("[TB] tie round %0d, previous winner was I: %0d", k, mLastI);
            i_re = 1'b1; d_re = 1'b1;
            i_addr = $urandom; d_addr = $urandom;
            cycle(); #1;
            vectors++; if (grant_d !== expD || grant_i !== !expD) begin miscompares++; $display("[TB] FAIL tie_grant_%0d: got d=%b i=%b want d=%b", k, grant_d, grant_i, expD); end
            vectors++; if (mem_addr !== (expD ? d_addr : i_addr)) begin miscompares++; $display("[TB] FAIL tie_addr_%0d: got %h want %h", k, mem_addr, expD ? d_addr : i_addr); end
            i_re = 1'b0; d_re = 1'b0;
            cycle();
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        i_re = 1'b1; i_addr = 32'h3000;
        cycle(); #1;
        vectors++; if (grant_i !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_i_grant: got %b want 1", grant_i); end
        for (int n = 0; n < 6; n++) begin
            mem_ack = 1'b1;
            if (n == 2) begin d_re = 1'b1; d_addr = 32'h4000; end
            #1;
            vectors++; if (grant_i !== 1'b1 || grant_d !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_hold_%0d: got i=%b d=%b want 1 0", n, grant_i, grant_d); end
            vectors++; if (d_ack !== 1'b0 || i_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_ack_%0d: got i=%b d=%b want 1 0", n, i_ack, d_ack); end
            cycle();
        end
        i_re = 1'b0; mem_ack = 1'b0;
        cycle(); #1;
        vectors++; if (grant_d !== 1'b0 || grant_i !== 1'b0 || mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_dead1: got i=%b d=%b re=%b want 0 0 0", grant_i, grant_d, mem_re); end
        cycle(); #1;
        vectors++; if (grant_d !== 1'b0 || grant_i !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_dead2: got i=%b d=%b want 0 0", grant_i, grant_d); end
        cycle(); #1;
        vectors++; if (grant_d !== 1'b1 || mem_addr !== 32'h4000 || mem_re !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_d_grant: got d=%b addr=%h re=%b want 1 00004000 1", grant_d, mem_addr, mem_re); end
        d_re = 1'b0;
        cycle();
        cycle();
    endtask

    task automatic test_timeout();
        int gnt;
        gnt = 0;
        i_re = 1'b1; i_addr = 32'h6000; mem_ack = 1'b0;
        cycle(); #1;
        for (int n = 0; n < 20 && grant_i === 1'b1; n++) begin
            gnt++;
            cycle(); #1;
        end
        vectors++; if (gnt !== TIMEOUT_CYCLES) begin miscompares++; $display("[TB] FAIL to_grant_cycles: got %0d want %0d", gnt, TIMEOUT_CYCLES); end
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL to_err_set: got %b want 1", timeout_err); end
        vectors++; if (mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL to_release_strobe: got %b want 0", mem_re); end
        cycle(); #1;
        vectors++; if (grant_i !== 1'b0) begin miscompares++; $display("[TB] FAIL to_idle: got %b want 0", grant_i); end
        cycle(); #1;
        vectors++; if (grant_i !== 1'b1) begin miscompares++; $display("[TB] FAIL to_rearb: got %b want 1", grant_i); end
        mem_ack = 1'b1;
        cycle();
        i_re = 1'b0; mem_ack = 1'b0;
        cycle();
        cycle();
        d_wr = 1'b1; d_addr = 32'h7000; d_wdata = 32'h0BADF00D;
        cycle();
        mem_ack = 1'b1;
        #1;
        vectors++; if (d_ack !== 1'b1) begin miscompares++; $display("[TB] FAIL to_ok_ack: got %b want 1", d_ack); end
        cycle();
        d_wr = 1'b0; mem_ack = 1'b0;
        cycle();
        cycle(); #1;
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL to_err_sticky: got %b want 1", timeout_err); end
    endtask

    task automatic test_reset_mid();
        d_wr = 1'b1; d_re = 1'b1; d_addr = 32'h5000;
        cycle(); #1;
        vectors++; if (grant_d !== 1'b1 || mem_wr !== 1'b1) begin miscompares++; $display("[TB] FAIL rstmid_pre: got grant=%b wr=%b want 1 1", grant_d, mem_wr); end
        #1;
        ctr_rst = 1'b1;
        #1;
        vectors++; if (mem_wr !== 1'b0 || mem_re !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_strobes: got wr=%b re=%b want 0 0", mem_wr, mem_re); end
        vectors++; if (grant_d !== 1'b0 || mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL rstmid_grant: got grant=%b addr=%h want 0 0", grant_d, mem_addr); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_err: got %b want 0", timeout_err); end
        d_wr = 1'b0; d_re = 1'b0;
        #1;
        ctr_rst = 1'b0;
        modelReset();
    endtask

    task automatic test_random();
        bit gI;
        bit gD;
        logic [ADDR_W-1:0]    eAddr;
        logic                 eRe;
        logic                 eWr;
        logic [WORD_SIZE-1:0] eWdata;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 5) == 0) i_re = ~i_re;
            if ($urandom_range(0, 5) == 0) d_re = ~d_re;
            if ($urandom_range(0, 7) == 0) d_wr = ~d_wr;
            i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; mem_rdata = $urandom;
            mem_ack = ($urandom_range(0, 9) < 6);
            #1;
            gI = (mOwner == OWN_I);
            gD = (mOwner == OWN_D);
            eAddr  = gI ? i_addr : (gD ? d_addr : '0);
            eRe    = gI ? i_re : (gD ? d_re : 1'b0);
            eWr    = gD ? d_wr : 1'b0;
            eWdata = gD ? d_wdata : '0;
            vectors++; if (grant_i !== gI || grant_d !== gD) begin miscompares++; $display("[TB] FAIL rnd_grant @%0d: got i=%b d=%b want i=%b d=%b", n, grant_i, grant_d, gI, gD); end
            vectors++; if (mem_addr !== eAddr) begin miscompares++; $display("[TB] FAIL rnd_addr @%0d: got %h want %h", n, mem_addr, eAddr); end
            vectors++; if (mem_re !== eRe || mem_wr !== eWr) begin miscompares++; $display("[TB] FAIL rnd_strobes @%0d: got re=%b wr=%b want re=%b wr=%b", n, mem_re, mem_wr, eRe, eWr); end
            vectors++; if (mem_wdata !== eWdata) begin miscompares++; $display("[TB] FAIL rnd_wdata @%0d: got %h want %h", n, mem_wdata, eWdata); end
            vectors++; if (i_ack !== (gI & mem_ack) || d_ack !== (gD & mem_ack)) begin miscompares++; $display("[TB] FAIL rnd_acks @%0d: got i=%b d=%b want i=%b d=%b", n, i_ack, d_ack, gI & mem_ack, gD & mem_ack); end
            vectors++; if (i_rdata !== (gI ? mem_rdata : '0)) begin miscompares++; $display("[TB] FAIL rnd_i_rdata @%0d: got %h want %h", n, i_rdata, gI ? mem_rdata : '0); end
            vectors++; if (d_rdata !== (gD ? mem_rdata : '0)) begin miscompares++; $display("[TB] FAIL rnd_d_rdata @%0d: got %h want %h", n, d_rdata, gD ? mem_rdata : '0); end
            vectors++; if (timeout_err !== mErr) begin miscompares++; $display("[TB] FAIL rnd_err @%0d: got %b want %b", n, timeout_err, mErr); end
            cycle();
        end
    endtask

    // Run the scenarios in order; the tie check relies on the I-burst having won last.
    initial begin
        ctr_rst = 1'b1;
        i_addr = '0; i_re = 1'b0; d_addr = '0; d_re = 1'b0; d_wr = 1'b0;
        d_wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        modelReset();
        test_reset();
        test_d_write();
        test_i_burst();
        test_tie();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
